out_pingpong_buffer: RTL and testbench

Double-banked (ping-pong) output capture buffer for the CNN output path. It accepts result beats from the compute pipeline into one bank while the other bank drains to a downstream consumer. The consumer can be the DMA or the host read path. Frame length is runtime-programmable, and a `done` pulse is raised per completed frame. Valid/ready on both sides gives backpressure without beat loss.

---
 rtl/out_pingpong_buffer_pkg.sv | 13 +
 rtl/out_pingpong_buffer_if.sv | 32 +++
 rtl/out_bank_ram.sv | 33 +++
 rtl/out_pingpong_buffer.sv | 139 +++++++++++++
 tb/tb_out_pingpong_buffer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/out_pingpong_buffer_pkg.sv
// Shared constants for the ping-pong output capture buffer.
//   OPB_WIDTH      default data width in bits
//   OPB_DEPTH      default words per bank
//   OPB_LOG2_DEPTH default per-bank address width
//   N_BANKS        number of banks (ping and pong)
package out_pingpong_buffer_pkg;

    localparam int OPB_WIDTH      = 256;
    localparam int OPB_DEPTH      = 8;
    localparam int OPB_LOG2_DEPTH = 3;
    localparam int N_BANKS        = 2;

endpackage

// File: rtl/out_pingpong_buffer_if.sv
// Handshake bundle for the ping-pong output buffer.
//   slave  : the buffer (accepts write beats, presents read words, reports status)
//   master : the environment (compute pipeline on the write side, consumer on the read side)
// Signals: clr, dat_num, dat_vld/dat/dat_rdy, done, rd_vld/rd_dat/rd_last/rd_rdy, bank_full.
interface out_pingpong_buffer_if
    import out_pingpong_buffer_pkg::*;
#(
    parameter int WIDTH      = OPB_WIDTH,
    parameter int LOG2_DEPTH = OPB_LOG2_DEPTH
) ();
    logic                  clr;
    logic [LOG2_DEPTH-1:0] dat_num;
    logic                  dat_vld;
    logic [WIDTH-1:0]      dat;
    logic                  dat_rdy;
    logic                  done;
    logic                  rd_vld;
    logic [WIDTH-1:0]      rd_dat;
    logic                  rd_last;
    logic                  rd_rdy;
    logic [N_BANKS-1:0]    bank_full;

    modport slave (
        input  clr, dat_num, dat_vld, dat, rd_rdy,
        output dat_rdy, done, rd_vld, rd_dat, rd_last, bank_full
    );

    modport master (
        output clr, dat_num, dat_vld, dat, rd_rdy,
        input  dat_rdy, done, rd_vld, rd_dat, rd_last, bank_full
    );
endinterface

// File: rtl/out_bank_ram.sv
// Simple dual-port RAM holding both banks, addressed by {bank, addr}.
//   clk, rst_n : clock, async active-low reset (read register only)
//   we_i/wa_i/wd_i : write port
//   re_i/ra_i      : synchronous read request
//   rd_o           : registered read data, resets to 0
module out_bank_ram #(
    parameter int WIDTH = 256,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    wa_i,
    input  logic [WIDTH-1:0] wd_i,
    input  logic             re_i,
    input  logic [AW-1:0]    ra_i,
    output logic [WIDTH-1:0] rd_o
);
    logic [WIDTH-1:0] mem_q [2**AW];
    logic [WIDTH-1:0] rd_q;

    // Storage is not reset; only the output register has a defined reset value.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[wa_i] <= wd_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rd_q <= '0;
        else if (re_i) rd_q <= mem_q[ra_i];
    end

    assign rd_o = rd_q;
endmodule

// File: rtl/out_pingpong_buffer.sv
// Double-banked output capture buffer: one bank fills from the compute
// pipeline while the other drains to the consumer through a one-deep
// registered read stage.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of out_pingpong_buffer_if (write beats, read words,
//                soft clear, frame length, done pulse, per-bank full flags)
module out_pingpong_buffer
    import out_pingpong_buffer_pkg::*;
#(
    parameter int WIDTH      = OPB_WIDTH,
    parameter int DEPTH      = OPB_DEPTH,
    parameter int log2_DEPTH = OPB_LOG2_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    out_pingpong_buffer_if.slave bus
);
    typedef logic [log2_DEPTH-1:0] addr_t;

    logic [N_BANKS-1:0]             full_q, full_d;
    logic [N_BANKS-1:0][log2_DEPTH-1:0] len_q, len_d;
    logic  wb_q, wb_d, rb_q, rb_d;
    addr_t wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic  fetched_q, fetched_d;
    logic  rd_vld_q, rd_vld_d, rd_last_q, rd_last_d, done_q, done_d;

    logic  wr_acc, wr_last, fetch, xfer;
    addr_t wr_len;

    always_comb begin
        full_d    = full_q;
        len_d     = len_q;
        wb_d      = wb_q;
        rb_d      = rb_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        fetched_d = fetched_q;
        rd_vld_d  = rd_vld_q;
        rd_last_d = rd_last_q;

        wr_acc  = bus.dat_vld & ~full_q[wb_q];
        // The first beat uses the live length so a frame may be a single word;
        // later beats use the latched copy so mid-frame changes are ignored.
        wr_len  = (wr_addr_q == '0) ? bus.dat_num : len_q[wb_q];
        wr_last = (wr_addr_q == wr_len);
        done_d  = wr_acc & wr_last;

        xfer  = rd_vld_q & bus.rd_rdy;
        fetch = full_q[rb_q] & ~fetched_q & (~rd_vld_q | bus.rd_rdy);

        if (wr_acc) begin
            if (wr_addr_q == '0) len_d[wb_q] = bus.dat_num;
            if (wr_last) begin
                wr_addr_d    = '0;
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
            end else begin
                wr_addr_d = wr_addr_q + 1'b1;
            end
        end

        if (fetch) begin
            rd_vld_d  = 1'b1;
            rd_last_d = (rd_addr_q == len_q[rb_q]);
            rd_addr_d = rd_addr_q + 1'b1;
            if (rd_addr_q == len_q[rb_q]) fetched_d = 1'b1;
        end else if (xfer) begin
            rd_vld_d  = 1'b0;
            rd_last_d = 1'b0;
        end

        // Release happens only on the last word, when no fetch can be pending
        // for this bank; the next bank starts fetching one cycle later.
        if (xfer && rd_last_q) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
            rd_addr_d    = '0;
            fetched_d    = 1'b0;
        end

        if (bus.clr) begin
            full_d    = '0;
            wb_d      = 1'b0;
            rb_d      = 1'b0;
            wr_addr_d = '0;
            rd_addr_d = '0;
            fetched_d = 1'b0;
            rd_vld_d  = 1'b0;
            rd_last_d = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= '0;
            len_q     <= '0;
            wb_q      <= 1'b0;
            rb_q      <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            fetched_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            full_q    <= full_d;
            len_q     <= len_d;
            wb_q      <= wb_d;
            rb_q      <= rb_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            fetched_q <= fetched_d;
            rd_vld_q  <= rd_vld_d;
            rd_last_q <= rd_last_d;
            done_q    <= done_d;
        end
    end

    out_bank_ram #(
        .WIDTH (WIDTH),
        .AW    (log2_DEPTH + 1)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we_i  (wr_acc & ~bus.clr),
        .wa_i  ({wb_q, wr_addr_q}),
        .wd_i  (bus.dat),
        .re_i  (fetch & ~bus.clr),
        .ra_i  ({rb_q, rd_addr_q}),
        .rd_o  (bus.rd_dat)
    );

    assign bus.dat_rdy   = ~full_q[wb_q];
    assign bus.done      = done_q;
    assign bus.rd_vld    = rd_vld_q;
    assign bus.rd_last   = rd_last_q;
    assign bus.bank_full = full_q;
endmodule

// File: tb/tb_out_pingpong_buffer.sv
module tb_out_pingpong_buffer;
    localparam int W = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    out_pingpong_buffer_if #(.WIDTH(W), .LOG2_DEPTH(3)) bus ();

    out_pingpong_buffer #(.WIDTH(W), .DEPTH(8), .log2_DEPTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: frames are collected whole and queued for the reader;
    // a bank is "occupied" from frame completion until its last word is read.
    logic [W-1:0] m_partial[$];
    logic [W-1:0] exp_dat[$];
    logic         exp_last[$];
    int m_cnt = 0, m_len = 0, m_full = 0;
    logic exp_done = 1'b0;
    logic held = 1'b0, held_last = 1'b0;
    logic [W-1:0] held_dat = '0;
    int cyc = 0, n_reads = 0, n_lasts = 0, n_done = 0;
    int xfer_cyc[$];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_partial.delete(); exp_dat.delete(); exp_last.delete();
                m_cnt = 0; m_full = 0; exp_done = 1'b0; held = 1'b0;
            end else begin
                cyc++;
                if (held) begin
                    check_val("hold_vld", bus.rd_vld, 1);
                    check_val("hold_dat", bus.rd_dat, held_dat);
                    check_val("hold_last", bus.rd_last, held_last);
                end
                held      = bus.rd_vld && !bus.rd_rdy && !bus.clr;
                held_dat  = bus.rd_dat;
                held_last = bus.rd_last;
                exp_done  = 1'b0;
                if (bus.clr) begin
                    m_partial.delete(); exp_dat.delete(); exp_last.delete();
                    m_cnt = 0; m_full = 0;
                end else begin
                    if (bus.dat_vld && m_full < 2) begin
                        if (m_cnt == 0) m_len = int'(bus.dat_num);
                        m_partial.push_back(bus.dat);
                        m_cnt++;
                        if (m_cnt == m_len + 1) begin
                            for (int i = 0; i <= m_len; i++) begin
                                exp_dat.push_back(m_partial[i]);
                                exp_last.push_back(i == m_len);
                            end
                            m_partial.delete();
                            m_cnt = 0;
                            m_full++;
                            exp_done = 1'b1;
                        end
                    end
                    if (bus.rd_vld && bus.rd_rdy) begin
                        if (exp_dat.size() == 0) begin
                            check_val("rd_extra", 1, 0);
                        end else begin
                            check_val("rd_dat", bus.rd_dat, exp_dat.pop_front());
                            check_val("rd_last", bus.rd_last, exp_last.pop_front());
                            if (bus.rd_last) begin
                                m_full--;
                                n_lasts++;
                            end
                            n_reads++;
                            xfer_cyc.push_back(cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check_val("dat_rdy", bus.dat_rdy, m_full < 2);
                check_val("bank_cnt", $countones(bus.bank_full), m_full);
                check_val("done", bus.done, exp_done);
                if (bus.done) n_done++;
            end
        end
    end

    task automatic send_beat(input logic [W-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        bus.dat_vld = 1'b1;
        bus.dat     = d;
        while (!bus.dat_rdy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check_val("wr_timeout", 0, 1);
        @(posedge clk);
        #1 bus.dat_vld = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_dat.size() != 0 || bus.rd_vld || m_full != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check_val("drain_timeout", 0, 1);
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    int r0, l0, d0;
    bit stop_rdy;

    initial begin
        bus.clr = 1'b0; bus.dat_num = '0; bus.dat_vld = 1'b0; bus.dat = '0; bus.rd_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_dat_rdy", bus.dat_rdy, 1);
        check_val("rst_done", bus.done, 0);
        check_val("rst_rd_vld", bus.rd_vld, 0);
        check_val("rst_rd_last", bus.rd_last, 0);
        check_val("rst_rd_dat", bus.rd_dat, 0);
        check_val("rst_bank_full", bus.bank_full, 0);
        @(negedge clk) rst_n = 1'b1;

        // Single frame with explicit read latency.
        bus.rd_rdy = 1'b1;
        bus.dat_num = 3'd3;
        for (int i = 0; i < 4; i++) send_beat(W'(8'hA0 + i));
        @(negedge clk);
        check_val("lat_not_yet", bus.rd_vld, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("seq_vld", bus.rd_vld, 1);
            check_val("seq_dat", bus.rd_dat, W'(8'hA0 + i));
            check_val("seq_last", bus.rd_last, i == 3);
        end
        wait_drain();

        // Backpressure fill: both banks full, then drain with one bubble.
        bus.rd_rdy = 1'b0;
        bus.dat_num = 3'd7;
        d0 = n_done;
        for (int i = 0; i < 16; i++) send_beat(W'(16'h1000 + i));
        @(negedge clk);
        bus.dat_vld = 1'b1;
        bus.dat = W'(16'h1010);
        repeat (3) @(negedge clk);
        check_val("bp_dat_rdy", bus.dat_rdy, 0);
        check_val("bp_bank_full", bus.bank_full, 2'b11);
        check_val("bp_done_cnt", n_done - d0, 2);
        bus.dat_vld = 1'b0;
        xfer_cyc.delete();
        bus.rd_rdy = 1'b1;
        wait_drain();
        check_val("bp_xfers", xfer_cyc.size(), 16);
        if (xfer_cyc.size() == 16) begin
            for (int i = 1; i < 16; i++)
                check_val("bp_gap", xfer_cyc[i] - xfer_cyc[i-1], (i == 8) ? 2 : 1);
        end
        check_val("bp_rdy_back", bus.dat_rdy, 1);

        // Single-word frames.
        r0 = n_reads; l0 = n_lasts; d0 = n_done;
        bus.dat_num = 3'd0;
        for (int i = 1; i <= 3; i++) send_beat(W'(i));
        wait_drain();
        check_val("sw_done", n_done - d0, 3);
        check_val("sw_reads", n_reads - r0, 3);
        check_val("sw_lasts", n_lasts - l0, 3);

        // Length change mid-frame is ignored.
        r0 = n_reads; l0 = n_lasts;
        bus.dat_num = 3'd5;
        send_beat(W'(32'hC0)); send_beat(W'(32'hC1));
        bus.dat_num = 3'd2;
        for (int i = 2; i < 6; i++) send_beat(W'(32'hC0 + i));
        wait_drain();
        check_val("lc_reads", n_reads - r0, 6);
        check_val("lc_lasts", n_lasts - l0, 1);

        // Random stalls, 10 frames of 5 words.
        r0 = n_reads;
        bus.dat_num = 3'd4;
        stop_rdy = 1'b0;
        fork
            begin
                for (int i = 0; i < 50; i++) begin
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                    send_beat(rand_word());
                end
                stop_rdy = 1'b1;
            end
            begin
                for (int n = 0; n < 5000 && !stop_rdy; n++) begin
                    @(negedge clk);
                    bus.rd_rdy = ($urandom_range(0, 2) != 0);
                end
            end
        join
        bus.rd_rdy = 1'b1;
        wait_drain();
        check_val("rs_reads", n_reads - r0, 50);

        // Soft clear mid-frame.
        r0 = n_reads;
        bus.dat_num = 3'd2;
        send_beat(W'(32'hDEAD0)); send_beat(W'(32'hDEAD1));
        @(negedge clk) bus.clr = 1'b1;
        @(negedge clk) bus.clr = 1'b0;
        check_val("clr_bank_full", bus.bank_full, 0);
        check_val("clr_rd_vld", bus.rd_vld, 0);
        for (int i = 0; i < 3; i++) send_beat(W'(32'hE0 + i));
        wait_drain();
        check_val("clr_reads", n_reads - r0, 3);

        // Reset mid-frame, then a clean frame.
        r0 = n_reads;
        bus.dat_num = 3'd3;
        send_beat(W'(32'hF0)); send_beat(W'(32'hF1));
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk) #1;
        check_val("rrst_dat_rdy", bus.dat_rdy, 1);
        check_val("rrst_bank_full", bus.bank_full, 0);
        check_val("rrst_rd_vld", bus.rd_vld, 0);
        @(negedge clk) rst_n = 1'b1;
        bus.dat_num = 3'd1;
        send_beat(W'(32'hAB0)); send_beat(W'(32'hAB1));
        wait_drain();
        check_val("rrst_reads", n_reads - r0, 2);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
